// File: rtl/alu_mc_if.sv
// alu_mc_if: request/response valid-ready bundle for alu_mc
interface alu_mc_if #(
    parameter int WIDTH = 32,
    parameter int OPW   = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [OPW-1:0]   operation;
    logic [WIDTH-1:0] port_A;
    logic [WIDTH-1:0] port_B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] data_out;
    logic             illegal;
    modport master (
        output in_valid, operation, port_A, port_B, out_ready,
        input  in_ready, out_valid, data_out, illegal
    );
    modport slave (
        input  in_valid, operation, port_A, port_B, out_ready,
        output in_ready, out_valid, data_out, illegal
    );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU behind a valid/ready handshake; ALU_MC_MULDIV_EN adds iterative MUL/DIV
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int OPW   = 5
) (
    input logic     clk,
    input logic     rst,
    alu_mc_if.slave bus
);
    localparam int SW = $clog2(WIDTH);
`ifdef ALU_MC_MULDIV_EN
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
`else
    typedef enum logic [0:0] {IDLE, DONE} state_t;
`endif
    state_t           state, n_st;
    logic             valid, ill, n_ill, accept;
    logic [WIDTH-1:0] res, n_res, a, b;
    logic [SW-1:0]    sh;
    assign a             = bus.port_A;
    assign b             = bus.port_B;
    assign sh            = b[SW-1:0];
    assign bus.in_ready  = (state == IDLE) || (state == DONE && bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = valid;
    assign bus.data_out  = res;
    assign bus.illegal   = ill;
`ifdef ALU_MC_MULDIV_EN
    localparam logic [WIDTH-1:0] ONES = '1;
    localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};
    logic [OPW-1:0]   opc;
    logic             sa, sb, neg_a, neg_b, is_hi, dz, ov, nq, nr, sel, ge;
    logic [WIDTH-1:0] ma, mb, hi, lo, d, n_hi, n_lo, df, qv, rv, fin;
    logic [WIDTH:0]   s, t;
    logic [2*WIDTH-1:0] p;
    logic [SW-1:0]    cnt;
    assign opc   = bus.operation;
    assign sa    = opc == OPW'(5) || opc == OPW'(7) || opc == OPW'(8) || opc == OPW'(9);
    assign sb    = opc == OPW'(5) || opc == OPW'(8) || opc == OPW'(9);
    assign is_hi = opc == OPW'(5) || opc == OPW'(6) || opc == OPW'(7) || opc == OPW'(9) || opc == OPW'(18);
    assign neg_a = sa & a[WIDTH-1];
    assign neg_b = sb & b[WIDTH-1];
    assign ma    = neg_a ? -a : a;
    assign mb    = neg_b ? -b : b;
    assign dz    = b == '0;
    assign ov    = sb && a == MINV && b == ONES;
    // hi/lo/d are shared: shift-add product register or restoring remainder/quotient pair
    always_comb begin
        s    = {1'b0, hi} + (lo[0] ? {1'b0, d} : '0);
        t    = {hi, lo[WIDTH-1]};
        ge   = t >= {1'b0, d};
        df   = t[WIDTH-1:0] - d;
        n_hi = state == MUL ? s[WIDTH:1] : ge ? df : t[WIDTH-1:0];
        n_lo = state == MUL ? {s[0], lo[WIDTH-1:1]} : {lo[WIDTH-2:0], ge};
        p    = nq ? -{n_hi, n_lo} : {n_hi, n_lo};
        qv   = nq ? -n_lo : n_lo;
        rv   = nr ? -n_hi : n_hi;
        fin  = state == MUL ? (sel ? p[2*WIDTH-1:WIDTH] : p[WIDTH-1:0]) : sel ? rv : qv;
    end
`endif
    always_comb begin
        n_res = '0;
        n_ill = 1'b0;
        n_st  = DONE;
        case (int'(bus.operation))
            1:       n_res = a + b;
            2, 11:   n_res = ~a;
            3:       n_res = a - b;
            10:      n_res = a & b;
            12:      n_res = a | b;
            13:      n_res = a ^ b;
            14:      n_res = a << sh;
            15:      n_res = a >> sh;
            16:      n_res = $signed(a) >>> sh;
            24:      n_res = b;
`ifdef ALU_MC_MULDIV_EN
            4, 5, 6, 7: n_st = MUL;
            8, 9, 17, 18: begin
                n_st  = (dz || ov) ? DONE : DIV;
                n_res = dz ? (is_hi ? a : ONES) : ov ? (is_hi ? '0 : a) : '0;
            end
`endif
            default: n_ill = 1'b1;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            valid <= 1'b0;
            ill   <= 1'b0;
            res   <= '0;
`ifdef ALU_MC_MULDIV_EN
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            d     <= '0;
            nq    <= 1'b0;
            nr    <= 1'b0;
            sel   <= 1'b0;
`endif
        end else if (accept) begin
            state <= n_st;
            valid <= n_st == DONE;
            ill   <= n_ill;
            res   <= n_res;
`ifdef ALU_MC_MULDIV_EN
            cnt   <= '0;
            hi    <= '0;
            lo    <= ma;
            d     <= mb;
            nq    <= neg_a ^ neg_b;
            nr    <= neg_a;
            sel   <= is_hi;
`endif
        end else if (state == DONE) begin
            if (bus.out_ready) begin
                state <= IDLE;
                valid <= 1'b0;
            end
        end
`ifdef ALU_MC_MULDIV_EN
        else if (state == MUL || state == DIV) begin
            hi  <= n_hi;
            lo  <= n_lo;
            cnt <= cnt + 1'b1;
            if (cnt == SW'(WIDTH - 1)) begin
                state <= DONE;
                valid <= 1'b1;
                res   <= fin;
            end
        end
`endif
    end
endmodule
